// File: rtl/commit_thread_arbiter.sv
// Commit datapath arbiter shared by THREAD_NUM hardware threads.
// Round-robin grant of up to COMMIT_WIDTH ops per cycle, with a per-thread
// recovery lock. Grant outputs are combinational; state moves on clk rise.
// Optional starvation guard: define RSD_COMMIT_ARB_STARVE_GUARD_EN.
//
//   state       | meaning
//   LOCK_RUN    | thread may commit
//   LOCK_LOCKED | thread blocked until its recovery completes
module commit_thread_arbiter #(
   parameter int THREAD_NUM   = 2,
   parameter int COMMIT_WIDTH = 4,
   parameter int STARVE_LIMIT = 8,
   localparam int CNT_W = $clog2(COMMIT_WIDTH + 1),
   localparam int TID_W = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             commitEnable,
   input  logic [THREAD_NUM-1:0]            reqValid,
   input  logic [THREAD_NUM-1:0][CNT_W-1:0] reqCount,
   input  logic [THREAD_NUM-1:0]            recoveryReq,
   input  logic [THREAD_NUM-1:0]            recoveryDone,
   output logic                             grantValid,
   output logic [TID_W-1:0]                 grantThread,
   output logic [CNT_W-1:0]                 grantNum,
   output logic [THREAD_NUM-1:0]            threadLocked
);

   typedef enum logic {
      LOCK_RUN    = 1'b0,
      LOCK_LOCKED = 1'b1
   } lock_state_e;

   lock_state_e             lock_q [THREAD_NUM];
   lock_state_e             lock_d [THREAD_NUM];
   logic [TID_W-1:0]        rr_ptr;
   logic [THREAD_NUM-1:0]   eligible;
   logic                    rr_found;
   logic [TID_W-1:0]        rr_sel;
   logic                    pick_found;
   logic [TID_W-1:0]        pick_sel;

   // lock state register; reset releases every lock immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < THREAD_NUM; t++) lock_q[t] <= LOCK_RUN;
      end else begin
         for (int t = 0; t < THREAD_NUM; t++) lock_q[t] <= lock_d[t];
      end
   end

   // lock next state: a pending request always wins over done
   always_comb begin
      for (int t = 0; t < THREAD_NUM; t++) begin
         lock_d[t] = lock_q[t];
         case (lock_q[t])
            LOCK_RUN:    if (recoveryReq[t]) lock_d[t] = LOCK_LOCKED;
            LOCK_LOCKED: if (recoveryDone[t] && !recoveryReq[t]) lock_d[t] = LOCK_RUN;
            default:     lock_d[t] = LOCK_RUN;
         endcase
      end
   end

   // eligibility and lock status; reset masks grants while asserted
   always_comb begin
      for (int t = 0; t < THREAD_NUM; t++) begin
         threadLocked[t] = (lock_q[t] == LOCK_LOCKED);
         eligible[t]     = rst && commitEnable && reqValid[t] &&
                           (reqCount[t] != '0) && (lock_q[t] == LOCK_RUN);
      end
   end

   // round-robin search starting at rr_ptr, wrapping modulo THREAD_NUM
   always_comb begin
      int idx;
      idx      = 0;
      rr_found = 1'b0;
      rr_sel   = '0;
      for (int i = 0; i < THREAD_NUM; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= THREAD_NUM) idx = idx - THREAD_NUM;
         if (!rr_found && eligible[TID_W'(idx)]) begin
            rr_found = 1'b1;
            rr_sel   = TID_W'(idx);
         end
      end
   end

`ifdef RSD_COMMIT_ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0]  starve_cnt [THREAD_NUM];
   logic             force_found;
   logic [TID_W-1:0] force_sel;

   // starved threads jump the queue, lowest index first
   always_comb begin
      force_found = 1'b0;
      force_sel   = '0;
      for (int t = 0; t < THREAD_NUM; t++) begin
         if (!force_found && eligible[t] && (starve_cnt[t] == SC_W'(STARVE_LIMIT))) begin
            force_found = 1'b1;
            force_sel   = TID_W'(t);
         end
      end
   end

   // count consecutive denied-while-eligible cycles, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < THREAD_NUM; t++) starve_cnt[t] <= '0;
      end else begin
         for (int t = 0; t < THREAD_NUM; t++) begin
            if ((lock_q[t] == LOCK_LOCKED) || !eligible[t] ||
                (grantValid && (grantThread == TID_W'(t))))
               starve_cnt[t] <= '0;
            else if (starve_cnt[t] != SC_W'(STARVE_LIMIT))
               starve_cnt[t] <= starve_cnt[t] + SC_W'(1);
         end
      end
   end

   assign pick_found = force_found | rr_found;
   assign pick_sel   = force_found ? force_sel : rr_sel;
`else
   assign pick_found = rr_found;
   assign pick_sel   = rr_sel;
`endif

   // grant outputs, zeroed when nothing is granted
   always_comb begin
      grantValid  = pick_found;
      grantThread = '0;
      grantNum    = '0;
      if (pick_found) begin
         grantThread = pick_sel;
         grantNum    = (reqCount[pick_sel] > CNT_W'(COMMIT_WIDTH)) ?
                       CNT_W'(COMMIT_WIDTH) : reqCount[pick_sel];
      end
   end

   // round-robin pointer advances past the granted thread, else holds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_ptr <= '0;
      else if (grantValid)
         rr_ptr <= (grantThread == TID_W'(THREAD_NUM - 1)) ? '0 : grantThread + TID_W'(1);
   end

endmodule

// File: tb/tb_commit_thread_arbiter.sv
// Directed bench for commit_thread_arbiter: a default 2-thread instance and
// a 4-thread instance with STARVE_LIMIT=2 for the starvation guard scenario.
module tb_commit_thread_arbiter;

   logic            clk;
   logic            rst;
   logic            cen;
   logic [1:0]      rv;
   logic [1:0][2:0] rc;
   logic [1:0]      rreq;
   logic [1:0]      rdone;
   logic            gv;
   logic            gt;
   logic [2:0]      gn;
   logic [1:0]      tl;

   logic            cen4;
   logic [3:0]      rv4;
   logic [3:0][2:0] rc4;
   logic [3:0]      rreq4;
   logic [3:0]      rdone4;
   logic            gv4;
   logic [1:0]      gt4;
   logic [2:0]      gn4;
   logic [3:0]      tl4;

   int checks = 0;
   int errors = 0;

   commit_thread_arbiter #(.THREAD_NUM(2), .COMMIT_WIDTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst), .commitEnable(cen), .reqValid(rv), .reqCount(rc),
      .recoveryReq(rreq), .recoveryDone(rdone), .grantValid(gv),
      .grantThread(gt), .grantNum(gn), .threadLocked(tl)
   );

   commit_thread_arbiter #(.THREAD_NUM(4), .COMMIT_WIDTH(4), .STARVE_LIMIT(2)) dut4 (
      .clk(clk), .rst(rst), .commitEnable(cen4), .reqValid(rv4), .reqCount(rc4),
      .recoveryReq(rreq4), .recoveryDone(rdone4), .grantValid(gv4),
      .grantThread(gt4), .grantNum(gn4), .threadLocked(tl4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      #3;
      cen = 1'b1; rv = 2'b11; rc[0] = 3'd3; rc[1] = 3'd2;
      #1;
      checks++;
      if ({gv, gt, gn} !== 5'b0) begin
         errors++;
         $display("FAIL reset_grant: got v=%0b t=%0d n=%0d, expected 0/0/0", gv, gt, gn);
      end
      checks++;
      if (tl !== 2'b00) begin
         errors++;
         $display("FAIL reset_locked: got %b, expected 00", tl);
      end
      @(negedge clk);
      #1;
      checks++;
      if (gv !== 1'b0) begin
         errors++;
         $display("FAIL reset_after_edge: got v=%0b, expected 0", gv);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_round_robin();
      cen = 1'b1; rv = 2'b11; rc[0] = 3'd3; rc[1] = 3'd2;
      for (int i = 0; i < 4; i++) begin
         logic       et;
         logic [2:0] en;
         et = i[0];
         en = et ? 3'd2 : 3'd3;
         #1;
         checks++;
         if ({gv, gt, gn} !== {1'b1, et, en}) begin
            errors++;
            $display("FAIL rr_alternate cycle %0d: got v=%0b t=%0d n=%0d, expected v=1 t=%0d n=%0d",
                     i, gv, gt, gn, et, en);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_saturate();
      rv = 2'b01; rc[0] = 3'd6; rc[1] = 3'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({gv, gt, gn} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL sat_width cycle %0d: got v=%0b t=%0d n=%0d, expected v=1 t=0 n=4",
                     i, gv, gt, gn);
         end
         @(negedge clk);
      end
      rc[0] = 3'd4;
      #1;
      checks++;
      if ({gv, gt, gn} !== {1'b1, 1'b0, 3'd4}) begin
         errors++;
         $display("FAIL sat_exact: got v=%0b t=%0d n=%0d, expected v=1 t=0 n=4", gv, gt, gn);
      end
      @(negedge clk);
      rc[0] = 3'd0;
      #1;
      checks++;
      if ({gv, gt, gn} !== 5'b0) begin
         errors++;
         $display("FAIL zero_count: got v=%0b t=%0d n=%0d, expected 0/0/0", gv, gt, gn);
      end
      @(negedge clk);
      rv = 2'b00; rc[0] = 3'd1;
      #1;
      checks++;
      if (gv !== 1'b0) begin
         errors++;
         $display("FAIL no_valid: got v=%0b, expected 0", gv);
      end
      @(negedge clk);
   endtask

   task automatic test_recovery();
      rv = 2'b11; rc[0] = 3'd1; rc[1] = 3'd2; rreq = 2'b10;
      #1;
      checks++;
      if ({gv, gt, gn, tl} !== {1'b1, 1'b1, 3'd2, 2'b00}) begin
         errors++;
         $display("FAIL rec_same_cycle: got v=%0b t=%0d n=%0d lk=%b, expected v=1 t=1 n=2 lk=00",
                  gv, gt, gn, tl);
      end
      @(negedge clk);
      rreq = 2'b00;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({gv, gt, gn, tl} !== {1'b1, 1'b0, 3'd1, 2'b10}) begin
            errors++;
            $display("FAIL rec_locked cycle %0d: got v=%0b t=%0d n=%0d lk=%b, expected v=1 t=0 n=1 lk=10",
                     i, gv, gt, gn, tl);
         end
         @(negedge clk);
      end
      rreq = 2'b10; rdone = 2'b10;
      #1;
      checks++;
      if ({gv, gt, tl} !== {1'b1, 1'b0, 2'b10}) begin
         errors++;
         $display("FAIL rec_req_done: got v=%0b t=%0d lk=%b, expected v=1 t=0 lk=10", gv, gt, tl);
      end
      @(negedge clk);
      rreq = 2'b00;
      #1;
      checks++;
      if ({gv, gt, tl} !== {1'b1, 1'b0, 2'b10}) begin
         errors++;
         $display("FAIL rec_lock_kept: got v=%0b t=%0d lk=%b, expected v=1 t=0 lk=10", gv, gt, tl);
      end
      @(negedge clk);
      rdone = 2'b00;
      #1;
      checks++;
      if ({gv, gt, gn, tl} !== {1'b1, 1'b1, 3'd2, 2'b00}) begin
         errors++;
         $display("FAIL rec_release: got v=%0b t=%0d n=%0d lk=%b, expected v=1 t=1 n=2 lk=00",
                  gv, gt, gn, tl);
      end
      @(negedge clk);
   endtask

   task automatic test_commit_disable();
      #1;
      checks++;
      if ({gv, gt} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL dis_prep: got v=%0b t=%0d, expected v=1 t=0", gv, gt);
      end
      @(negedge clk);
      cen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({gv, gt, gn} !== 5'b0) begin
            errors++;
            $display("FAIL dis_idle cycle %0d: got v=%0b t=%0d n=%0d, expected 0/0/0", i, gv, gt, gn);
         end
         @(negedge clk);
      end
      cen = 1'b1;
      #1;
      checks++;
      if ({gv, gt, gn} !== {1'b1, 1'b1, 3'd2}) begin
         errors++;
         $display("FAIL dis_resume: got v=%0b t=%0d n=%0d, expected v=1 t=1 n=2", gv, gt, gn);
      end
      @(negedge clk);
      rreq = 2'b11;
      #1;
      checks++;
      if ({gv, gt} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL all_lock_entry: got v=%0b t=%0d, expected v=1 t=0", gv, gt);
      end
      @(negedge clk);
      rreq = 2'b00;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({gv, tl} !== {1'b0, 2'b11}) begin
            errors++;
            $display("FAIL all_locked cycle %0d: got v=%0b lk=%b, expected v=0 lk=11", i, gv, tl);
         end
         @(negedge clk);
      end
      rdone = 2'b11;
      #1;
      checks++;
      if (gv !== 1'b0) begin
         errors++;
         $display("FAIL all_done_cycle: got v=%0b, expected 0", gv);
      end
      @(negedge clk);
      rdone = 2'b00;
      #1;
      checks++;
      if ({gv, gt, tl} !== {1'b1, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL all_unlock: got v=%0b t=%0d lk=%b, expected v=1 t=1 lk=00", gv, gt, tl);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      rreq = 2'b01;
      #1;
      checks++;
      if ({gv, gt, gn} !== {1'b1, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL ar_lock_grant: got v=%0b t=%0d n=%0d, expected v=1 t=0 n=1", gv, gt, gn);
      end
      @(negedge clk);
      rreq = 2'b00;
      #1;
      checks++;
      if ({gv, gt, tl} !== {1'b1, 1'b1, 2'b01}) begin
         errors++;
         $display("FAIL ar_locked: got v=%0b t=%0d lk=%b, expected v=1 t=1 lk=01", gv, gt, tl);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({gv, gt, gn, tl} !== 7'b0) begin
         errors++;
         $display("FAIL ar_async_clear: got v=%0b t=%0d n=%0d lk=%b, expected 0/0/0/00", gv, gt, gn, tl);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({gv, gt, gn} !== {1'b1, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL ar_first_grant: got v=%0b t=%0d n=%0d, expected v=1 t=0 n=1", gv, gt, gn);
      end
      @(negedge clk);
      rv = 2'b00;
   endtask

   task automatic test_starve();
      logic [3:0] elig [4];
      logic [1:0] exp_t [4];
      elig[0] = 4'b1011; elig[1] = 4'b1010; elig[2] = 4'b1100; elig[3] = 4'b1100;
      exp_t[0] = 2'd0;   exp_t[1] = 2'd1;
`ifdef RSD_COMMIT_ARB_STARVE_GUARD_EN
      exp_t[2] = 2'd3;   exp_t[3] = 2'd2;
`else
      exp_t[2] = 2'd2;   exp_t[3] = 2'd3;
`endif
      cen4 = 1'b1;
      for (int t = 0; t < 4; t++) rc4[t] = 3'd1;
      for (int i = 0; i < 4; i++) begin
         rv4 = elig[i];
         #1;
         checks++;
         if ({gv4, gt4, gn4} !== {1'b1, exp_t[i], 3'd1}) begin
            errors++;
            $display("FAIL starve_order cycle %0d: got v=%0b t=%0d n=%0d, expected v=1 t=%0d n=1",
                     i + 1, gv4, gt4, gn4, exp_t[i]);
         end
         @(negedge clk);
      end
      rv4 = 4'b0000;
   endtask

   initial begin
      rst = 1'b0; cen = 1'b0; rv = '0; rc = '0; rreq = '0; rdone = '0;
      cen4 = 1'b0; rv4 = '0; rc4 = '0; rreq4 = '0; rdone4 = '0;
      test_reset();
      test_round_robin();
      test_saturate();
      test_recovery();
      test_commit_disable();
      test_async_reset();
      test_starve();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_thread_arbiter.md
COMMIT_THREAD_ARBITER -- requirements
Module: commit_thread_arbiter

Interface
REQ-001 The block SHALL have parameter THREAD_NUM, default 2, number of hardware threads sharing the commit datapath.
REQ-002 The block SHALL have parameter COMMIT_WIDTH, default 4, maximum ops committed per cycle.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, consecutive denied cycles before a thread is forced.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-low (0 = reset).
REQ-006 The block SHALL have port commitEnable, input, 1, global commit phase active.
REQ-007 The block SHALL have port reqValid, input, THREAD_NUM, thread has finished insn(s) at its active-list head.
REQ-008 The block SHALL have port reqCount, input, THREAD_NUM x clog2(COMMIT_WIDTH+1), finished-insn op range per thread.
REQ-009 The block SHALL have port recoveryReq, input, THREAD_NUM, commit-time recovery detected for the thread.
REQ-010 The block SHALL have port recoveryDone, input, THREAD_NUM, recovery manager finished the thread's recovery.
REQ-011 The block SHALL have port grantValid, output, 1, a thread is granted the commit datapath this cycle.
REQ-012 The block SHALL have port grantThread, output, clog2(THREAD_NUM), granted thread index.
REQ-013 The block SHALL have port grantNum, output, clog2(COMMIT_WIDTH+1), ops the granted thread may commit.
REQ-014 The block SHALL have port threadLocked, output, THREAD_NUM, thread is blocked in recovery.

Function
REQ-015 eligible[t] SHALL be reqValid[t] && reqCount[t]!=0 && !locked[t] && commitEnable.
REQ-016 Grant outputs SHALL be combinational from current inputs and registered state (zero-cycle latency); state SHALL update at the next rising edge.
REQ-017 Selection SHALL be round-robin: first eligible thread searching from rrPtr upward, modulo THREAD_NUM.
REQ-018 After a grant to thread t, rrPtr SHALL become (t+1) mod THREAD_NUM; with no grant rrPtr SHALL hold.
REQ-019 grantNum SHALL equal min(reqCount[grantThread], COMMIT_WIDTH); grantNum and grantThread SHALL be 0 when grantValid=0.
REQ-020 Per-thread lock FSM SHALL have states RUN and LOCKED: RUN->LOCKED on recoveryReq[t]; LOCKED->RUN on recoveryDone[t] with recoveryReq[t]=0.
REQ-021 recoveryReq[t] and recoveryDone[t] in the same cycle SHALL leave/put the thread in LOCKED.
REQ-022 A thread raising recoveryReq while eligible SHALL still be granted in that cycle (ops before the faulting op commit); locking takes effect next cycle.
REQ-023 threadLocked[t] SHALL reflect the registered lock state, not the same-cycle recoveryReq.
REQ-024 All threads LOCKED or commitEnable=0 SHALL give grantValid=0, with rrPtr and lock states otherwise unchanged.
REQ-025 The block SHALL issue at most one grant per cycle.

Reset
REQ-026 While rst=0: grantValid=0, grantThread=0, grantNum=0, threadLocked=all 0, rrPtr=0, all starvation counters=0.
REQ-027 Reset asserted mid-recovery SHALL clear LOCKED immediately (asynchronously); first grant after release SHALL follow rrPtr=0.

Configuration
REQ-028 Macro RSD_COMMIT_ARB_STARVE_GUARD_EN SHALL enable starvation protection; absent, arbitration SHALL be pure round-robin and no counters SHALL exist.
REQ-029 When enabled, starveCnt[t] SHALL increment (saturating at STARVE_LIMIT) each cycle thread t is eligible and not granted, and clear on grant, on leaving eligibility, or on LOCKED.
REQ-030 When enabled, any thread with starveCnt==STARVE_LIMIT SHALL be granted ahead of round-robin order, lowest index first among such threads.

Verification
REQ-031 Reset then both threads reqValid=1, reqCount={3,2}, continuous -> grants alternate T0(3),T1(2),T0(3)...
REQ-032 T0 reqCount=6 with COMMIT_WIDTH=4, T1 idle -> grantThread=0, grantNum=4 every cycle.
REQ-033 T1 granted with recoveryReq[1]=1 -> grant issued that cycle, threadLocked[1]=1 next cycle, only T0 granted until recoveryDone[1]; simultaneous req+done keeps lock.
REQ-034 commitEnable=0 for 3 cycles with both eligible -> grantValid=0, rrPtr unchanged, next grant resumes at prior rrPtr.
REQ-035 Guard enabled, THREAD_NUM=4, STARVE_LIMIT=2, thread-3 eligibility aligned so rotation skips it -> thread 3 forced on cycle 3; guard disabled -> rotation order unchanged.
REQ-036 rst driven 0 between clock edges while T0 LOCKED -> threadLocked=0 and grantValid=0 without waiting for clk.
